demux2_4_buf: RTL and testbench

- 1-to-2 registered demultiplexer for 4-bit data: the inverse of the team's 2:1 4-bit selector.
- Accepts one word per valid/ready handshake and steers it to output channel 0 or 1 according to select `s`.
- Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled channel does not block the other.
- Sits between a single producer and two consumers in the classroom datapath.

---
 rtl/demux_pkg.sv | 10 +
 rtl/demux2_4_buf_if.sv | 38 +++
 rtl/demux_slot.sv | 44 ++++
 rtl/demux2_4_buf.sv | 95 +++++++++
 tb/tb_demux2_4_buf.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1-to-2 registered 4-bit demux.
package demux_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux2_4_buf_if.sv
// Producer/consumer bundle for demux2_4_buf; cnt0/cnt1 exist only with DEMUX2_4_CNT_EN.
interface demux2_4_buf_if #(
  parameter int WIDTH = demux_pkg::DEF_WIDTH,
  parameter int CNT_W = demux_pkg::DEF_CNT_W
);
  logic [WIDTH-1:0] in_data;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic             proto_err;
`ifdef DEMUX2_4_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  // master: the surrounding producer and consumers; slave: the demux itself.
  modport master (
    output in_data, s, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, proto_err
`ifdef DEMUX2_4_CNT_EN
    , input cnt0, cnt1
`endif
  );

  modport slave (
    input  in_data, s, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, proto_err
`ifdef DEMUX2_4_CNT_EN
    , output cnt0, cnt1
`endif
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register with load/drain handshake; state is exported for debug and steering.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output slot_state_t      state
);
  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain, so drain+load in one cycle keeps the slot FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (state_q == SLOT_FULL && drain_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;
  assign state = state_q;
endmodule

// File: rtl/demux2_4_buf.sv
// 1-to-2 registered demux: steers each accepted word to slot[s]. Optional DEMUX2_4_CNT_EN
// adds per-channel completed-handshake counters cnt0/cnt1.
module demux2_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  demux2_4_buf_if.slave bus
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready depends combinationally on s and out[s]_ready only, never on in_valid;
  // a producer must hold in_valid, in_data and s steady until its word is accepted.
  slot_state_t      slot0_state, slot1_state;
  logic             accept, load0, load1;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] prev_data_q, prev_data_d;
  logic             prev_s_q, prev_s_d;
  logic             err_q, err_d;

  always_comb begin
    if (bus.s) bus.in_ready = (slot1_state == SLOT_EMPTY) || bus.out1_ready;
    else       bus.in_ready = (slot0_state == SLOT_EMPTY) || bus.out0_ready;
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign load0  = accept & ~bus.s;
  assign load1  = accept &  bus.s;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .load_data(bus.in_data),
    .drain_ready(bus.out0_ready), .valid(bus.out0_valid), .data(bus.out0_data),
    .state(slot0_state)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .load_data(bus.in_data),
    .drain_ready(bus.out1_ready), .valid(bus.out1_valid), .data(bus.out1_data),
    .state(slot1_state)
  );

  // Remember a stalled offer so the next cycle can be checked for withdrawal or change.
  always_comb begin
    pend_d      = bus.in_valid & ~bus.in_ready;
    prev_data_d = bus.in_data;
    prev_s_d    = bus.s;
    err_d       = err_q;
    if (pend_q && (!bus.in_valid || bus.in_data != prev_data_q || bus.s != prev_s_q))
      err_d = 1'b1;
`ifndef SYNTHESIS
    if (bus.in_valid && $isunknown(bus.s))
      err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      prev_data_q <= '0;
      prev_s_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      prev_data_q <= prev_data_d;
      prev_s_q    <= prev_s_d;
      err_q       <= err_d;
    end
  end

  assign bus.proto_err = err_q;

`ifdef DEMUX2_4_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + CNT_W'(bus.out0_valid & bus.out0_ready);
    cnt1_d = cnt1_q + CNT_W'(bus.out1_valid & bus.out1_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux2_4_buf.sv
// Directed bench for demux2_4_buf with a per-channel expected-word scoreboard.
module tb_demux2_4_buf;
  localparam int W = 4;
`ifdef DEMUX2_4_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux2_4_buf_if #(.WIDTH(W), .CNT_W(CW)) bus();

  demux2_4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output handshakes first, then push words being accepted.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out0_valid && bus.out0_ready) begin
        tests++;
        assert (exp0_q.size() > 0) else begin
          fails++;
          $error("FAIL ch0_extra: observed word %0h expected none", bus.out0_data);
        end
        if (exp0_q.size() > 0) check("ch0_data", 8'(bus.out0_data), 8'(exp0_q.pop_front()));
      end
      if (bus.out1_valid && bus.out1_ready) begin
        tests++;
        assert (exp1_q.size() > 0) else begin
          fails++;
          $error("FAIL ch1_extra: observed word %0h expected none", bus.out1_data);
        end
        if (exp1_q.size() > 0) check("ch1_data", 8'(bus.out1_data), 8'(exp1_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.s) exp1_q.push_back(bus.in_data);
        else       exp0_q.push_back(bus.in_data);
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    // Reset
    rst_n          = 1'b0;
    bus.in_data    = '0;
    bus.s          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    #1;
    check("rst_out0_valid", 8'(bus.out0_valid), 8'd0);
    check("rst_out1_valid", 8'(bus.out1_valid), 8'd0);
    check("rst_proto_err", 8'(bus.proto_err), 8'd0);
    check("rst_in_ready", 8'(bus.in_ready), 8'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic route
    bus.s = 1'b0; bus.in_data = 4'hA; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    check("basic_out0_valid", 8'(bus.out0_valid), 8'd1);
    check("basic_out0_data", 8'(bus.out0_data), 8'hA);
    check("basic_out1_valid", 8'(bus.out1_valid), 8'd0);
    bus.s = 1'b1; bus.in_data = 4'h5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    check("basic_out1_valid", 8'(bus.out1_valid), 8'd1);
    check("basic_out1_data", 8'(bus.out1_data), 8'h5);
    check("basic_out0_drained", 8'(bus.out0_valid), 8'd0);
    step();

    // Backpressure and no-bubble pass-through
    bus.out0_ready = 1'b0;
    bus.s = 1'b0; bus.in_data = 4'h3; bus.in_valid = 1'b1;
    step();
    bus.in_data = 4'h7;
    #1;
    check("bp_in_ready_low", 8'(bus.in_ready), 8'd0);
    step();
    check("bp_hold_data", 8'(bus.out0_data), 8'h3);
    check("bp_hold_valid", 8'(bus.out0_valid), 8'd1);
    bus.out0_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 8'(bus.in_ready), 8'd1);
    step();
    bus.in_valid = 1'b0;
    #1;
    check("bp_pass_valid", 8'(bus.out0_valid), 8'd1);
    check("bp_pass_data", 8'(bus.out0_data), 8'h7);
    step();
    check("bp_drained", 8'(bus.out0_valid), 8'd0);

    // Channel independence
    bus.out0_ready = 1'b0;
    bus.s = 1'b0; bus.in_data = 4'hE; bus.in_valid = 1'b1;
    step();
    bus.s = 1'b1; bus.in_data = 4'h1;
    step();
    check("ind_w1_valid", 8'(bus.out1_valid), 8'd1);
    check("ind_w1_data", 8'(bus.out1_data), 8'h1);
    bus.in_data = 4'h2;
    step();
    bus.in_valid = 1'b0;
    check("ind_w2_data", 8'(bus.out1_data), 8'h2);
    check("ind_ch0_held", 8'(bus.out0_data), 8'hE);
    step();
    bus.s = 1'b0;
    #1;
    check("ind_no_steer", 8'(bus.in_ready), 8'd0);
    check("ind_ch1_empty", 8'(bus.out1_valid), 8'd0);
    bus.out0_ready = 1'b1;
    step();
    check("proto_clean", 8'(bus.proto_err), 8'd0);

    // Protocol error: stalled word changes before acceptance
    bus.out0_ready = 1'b0;
    bus.s = 1'b0; bus.in_data = 4'h8; bus.in_valid = 1'b1;
    step();
    bus.in_data = 4'h9;
    step();
    bus.in_data = 4'hC;
    #1;
    check("perr_not_yet", 8'(bus.proto_err), 8'd0);
    step();
    bus.in_valid = 1'b0;
    check("perr_set", 8'(bus.proto_err), 8'd1);
    step();
    check("perr_sticky", 8'(bus.proto_err), 8'd1);
    bus.out0_ready = 1'b1;
    step();

    // Reset mid-stream with both slots full
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.s = 1'b0; bus.in_data = 4'hB; bus.in_valid = 1'b1;
    step();
    bus.s = 1'b1; bus.in_data = 4'hD;
    step();
    bus.in_valid = 1'b0;
    check("mid_full0", 8'(bus.out0_valid), 8'd1);
    check("mid_full1", 8'(bus.out1_valid), 8'd1);
    rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    #1;
    check("mid_rst_v0", 8'(bus.out0_valid), 8'd0);
    check("mid_rst_v1", 8'(bus.out1_valid), 8'd0);
    check("mid_rst_d0", 8'(bus.out0_data), 8'h0);
    check("mid_rst_d1", 8'(bus.out1_data), 8'h0);
    check("mid_rst_perr", 8'(bus.proto_err), 8'd0);
    #1 rst_n = 1'b1;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    step();

`ifdef DEMUX2_4_CNT_EN
    // Counter wrap: five channel-0 handshakes with a 2-bit counter
    bus.s = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = W'(i + 1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("cnt0_wrap", 8'(bus.cnt0), 8'd1);
    check("cnt1_zero", 8'(bus.cnt1), 8'd0);
`endif

    // Sustained throughput with alternating select and random data
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = W'($urandom_range(0, 15));
      bus.s = i[0];
      bus.in_data = w;
      #1;
      check("tput_in_ready", 8'(bus.in_ready), 8'd1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    check("q0_empty", 8'(exp0_q.size()), 8'd0);
    check("q1_empty", 8'(exp1_q.size()), 8'd0);
    check("final_perr", 8'(bus.proto_err), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
